// File: rtl/dmem_store_buffer.sv
// LEGv8 data memory with a posted in-order store buffer.
// Loads read combinationally, forwarding from the youngest buffered store to the same doubleword.
module dmem_store_buffer #(
    parameter int DEPTH    = 256,
    parameter int SB_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      MemRead,
    input  logic                      MemWrite,
    input  logic [63:0]               addr,
    input  logic [63:0]               w_data,
    input  logic                      drain,
    output logic [63:0]               r_data,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_empty,
    output logic                      align_err,
    output logic                      range_err
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   mem     [DEPTH];
    logic [IW-1:0] sb_idx  [SB_DEPTH];
    logic [63:0]   sb_data [SB_DEPTH];
    logic [PW-1:0] head, tail;

    logic [IW-1:0] idx;
    logic          in_range, access, do_enq, do_ret, fwd_hit;
    logic [63:0]   fwd_data;

    assign idx      = addr[IW+2:3];
    assign in_range = (addr[63:IW+3] == '0);
    assign access   = MemRead | MemWrite;
    assign do_enq   = MemWrite & in_range;
    // A full buffer always drains one entry, so an enqueue never has to stall.
    assign do_ret   = (sb_count != '0) & (~MemRead | drain | (sb_count == CW'(SB_DEPTH)));
    assign sb_empty = (sb_count == '0);

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((CW'(i) < sb_count) && (sb_idx[head + PW'(i)] == idx)) begin
                fwd_hit  = 1'b1;
                fwd_data = sb_data[head + PW'(i)];
            end
        end
    end

    assign r_data = (MemRead & ~MemWrite & in_range) ? (fwd_hit ? fwd_data : mem[idx]) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            sb_count  <= '0;
            align_err <= 1'b0;
            range_err <= 1'b0;
        end else begin
            if (do_enq) tail <= tail + 1'b1;
            if (do_ret) head <= head + 1'b1;
            case ({do_enq, do_ret})
                2'b10:   sb_count <= sb_count + 1'b1;
                2'b01:   sb_count <= sb_count - 1'b1;
                default: ;
            endcase
            if (access && (addr[2:0] != 3'b000)) align_err <= 1'b1;
            if (access && !in_range)             range_err <= 1'b1;
        end
    end

    // Buffer payload and the array itself are not reset; only the pointers are.
    always_ff @(posedge clk) begin
        if (!rst && do_enq) begin
            sb_idx[tail]  <= idx;
            sb_data[tail] <= w_data;
        end
        if (!rst && do_ret) mem[sb_idx[head]] <= sb_data[head];
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: queue/array reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_store_buffer;
    localparam int DEPTH    = 256;
    localparam int SB_DEPTH = 4;
    localparam int CW       = $clog2(SB_DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst, MemRead, MemWrite, drain;
    logic [63:0]   addr, w_data, r_data;
    logic [CW-1:0] sb_count;
    logic          sb_empty, align_err, range_err;

    int checks = 0;
    int failures = 0;

    dmem_store_buffer #(.DEPTH(DEPTH), .SB_DEPTH(SB_DEPTH)) dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
        .addr(addr), .w_data(w_data), .drain(drain), .r_data(r_data),
        .sb_count(sb_count), .sb_empty(sb_empty),
        .align_err(align_err), .range_err(range_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct { int idx; logic [63:0] data; } st_t;
    st_t         q[$];
    logic [63:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_align, m_range, model_ready;

    function automatic bit in_rng(logic [63:0] a);
        return a < 64'(DEPTH * 8);
    endfunction

    function automatic int a2i(logic [63:0] a);
        return int'((a >> 3) % DEPTH);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_align     = 0;
            m_range     = 0;
            model_ready = 1;
        end else if (model_ready) begin
            bit ret;
            ret = (q.size() != 0) && (!MemRead || drain || q.size() == SB_DEPTH);
            if ((MemRead || MemWrite) && addr[2:0] != 0) m_align = 1;
            if ((MemRead || MemWrite) && !in_rng(addr))  m_range = 1;
            if (ret) begin
                m_mem[q[0].idx]   = q[0].data;
                m_known[q[0].idx] = 1;
                void'(q.pop_front());
            end
            if (MemWrite && in_rng(addr)) q.push_back('{a2i(addr), w_data});
        end
    end

    always @(negedge clk) begin
        if (model_ready && !rst) begin
            logic [63:0] exp_r;
            bit          known;
            known = 1;
            exp_r = '0;
            if (MemRead && !MemWrite && in_rng(addr)) begin
                int k;
                k = -1;
                for (int i = 0; i < q.size(); i++) if (q[i].idx == a2i(addr)) k = i;
                if (k >= 0) exp_r = q[k].data;
                else begin
                    exp_r = m_mem[a2i(addr)];
                    known = m_known[a2i(addr)];
                end
            end
            if (known) check("r_data", r_data, exp_r);
            check("sb_count", 64'(sb_count), 64'(q.size()));
            check("sb_empty", 64'(sb_empty), 64'(q.size() == 0));
            check("align_err", 64'(align_err), 64'(m_align));
            check("range_err", 64'(range_err), 64'(m_range));
        end
    end

    // ---------------- stimulus ----------------
    // One cycle: inputs applied after the edge, returns mid-low-phase for literal checks.
    task automatic step(bit rd, bit wr, logic [63:0] a, logic [63:0] d, bit dr = 0, bit r = 0);
        @(posedge clk);
        #1;
        rst = r; MemRead = rd; MemWrite = wr; addr = a; w_data = d; drain = dr;
        @(negedge clk);
        #1;
    endtask

    function automatic logic [63:0] pre(int i);
        return (i == 2) ? 64'hAA : 64'h1000 + 64'(i);
    endfunction

    initial begin
        logic [63:0] vals [5];
        rst = 1; MemRead = 0; MemWrite = 0; addr = '0; w_data = '0; drain = 0;
        model_ready = 0;
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0);
        check("reset_sb_empty", 64'(sb_empty), 64'd1);
        check("reset_sb_count", 64'(sb_count), 64'd0);
        check("reset_errs", {62'd0, align_err, range_err}, 64'd0);

        // Preload the whole array through the store path.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 64'(i * 8), pre(i));
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

        step(1, 0, 64'h10, 0);
        check("load_preload", r_data, 64'hAA);
        check("load_preload_empty", 64'(sb_empty), 64'd1);

        step(1, 1, 64'h18, 64'h1234);
        check("ld_st_same_cycle_zero", r_data, 64'h0);
        step(1, 0, 64'h18, 0);
        check("fwd_1234", r_data, 64'h1234);
        check("fwd_count", 64'(sb_count), 64'd1);

        step(1, 1, 64'h20, 64'h1);
        step(1, 1, 64'h20, 64'h2);
        step(1, 1, 64'h20, 64'h3);
        step(1, 0, 64'h20, 0);
        check("fwd_youngest", r_data, 64'h3);
        check("full_count", 64'(sb_count), 64'd4);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("drained_empty", 64'(sb_empty), 64'd1);
        step(1, 0, 64'h20, 0);
        check("array4_is_3", r_data, 64'h3);

        for (int i = 0; i < 5; i++) begin
            vals[i] = 64'hC0DE_0000 + 64'(i * 17);
            step(1, 1, 64'h40 + 64'(i * 8), vals[i]);
        end
        check("forced_retire_count", 64'(sb_count), 64'd4);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 64'h40 + 64'(i * 8), 0);
            check("five_fwd_or_array", r_data, vals[i]);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 64'h40 + 64'(i * 8), 0);
            check("five_array", r_data, vals[i]);
        end

        step(1, 0, 64'h0C, 0);
        step(0, 0, 0, 0);
        check("align_set", 64'(align_err), 64'd1);
        step(0, 0, 0, 0);
        check("align_sticky", 64'(align_err), 64'd1);
        step(1, 0, 64'h0, 0);
        step(0, 1, 64'(DEPTH * 8), 64'hDEAD);
        step(1, 0, 64'(DEPTH * 8), 0);
        check("oor_load_zero", r_data, 64'h0);
        check("oor_store_count", 64'(sb_count), 64'd0);
        check("range_set", 64'(range_err), 64'd1);

        step(1, 1, 64'h30, 64'hBAD0);
        step(1, 1, 64'h38, 64'hBAD1);
        step(1, 0, 64'h30, 0);
        check("pending_two", 64'(sb_count), 64'd2);
        step(0, 0, 0, 0, 0, 1);
        step(1, 0, 64'h30, 0);
        check("rst_count", 64'(sb_count), 64'd0);
        check("rst_keep_30", r_data, 64'h1006);
        check("rst_clr_range", 64'(range_err), 64'd0);
        step(1, 0, 64'h38, 0);
        check("rst_keep_38", r_data, 64'h1007);

        for (int n = 0; n < 3000; n++) begin
            logic [63:0] a;
            int sel;
            sel = $urandom_range(0, 63);
            a = 64'($urandom_range(0, 15)) * 8;
            if (sel == 0) a = a | 64'($urandom_range(1, 7));
            else if (sel == 1) a = 64'(DEPTH * 8) + 64'($urandom_range(0, 255)) * 8;
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a,
                 {$urandom, $urandom}, $urandom_range(0, 7) == 0, $urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
